// File: rtl/conway_pingpong_buf.sv
// Double-buffered Life cell store.
// One bank is the display bank. It is scanned out, read by the engine for neighbours, and
// seeded while idle. The other bank receives the engine's next-generation writes.
// The banks swap on the first vblank rising edge after the frame's last cell has been written.
module conway_pingpong_buf #(
    parameter logic [9:0] X_MAX = 10'd639,
    parameter logic [8:0] Y_MAX = 9'd479,
    parameter int         GEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             vblank,
    output logic             start,
    input  logic [9:0]       rd_addr_x,
    input  logic [8:0]       rd_addr_y,
    output logic             rd_data,
    input  logic             wr_en,
    input  logic [9:0]       wr_addr_x,
    input  logic [8:0]       wr_addr_y,
    input  logic             wr_data,
    input  logic [9:0]       disp_addr_x,
    input  logic [8:0]       disp_addr_y,
    output logic             disp_data,
    input  logic             seed_wr_en,
    input  logic [9:0]       seed_addr_x,
    input  logic [8:0]       seed_addr_y,
    input  logic             seed_data,
    output logic             busy,
    output logic             bank_sel,
    output logic [GEN_W-1:0] gen_count
);
    localparam int COLS  = int'(X_MAX) + 1;
    localparam int ROWS  = int'(Y_MAX) + 1;
    localparam int DEPTH = COLS * ROWS;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, START, RUN, DONE} state_t;

    state_t           state_q;
    logic             start_q;
    logic             busy_q;
    logic             bank_sel_q;
    logic             bank_sel_d;
    logic             vblank_q;
    logic             disp_data_q;
    logic [GEN_W-1:0] gen_count_q;

    logic bank0_mem [DEPTH];
    logic bank1_mem [DEPTH];

    function automatic logic [AW-1:0] lin_addr(input logic [9:0] x, input logic [8:0] y);
        logic [31:0] a;
        a = 32'(y) * 32'(COLS) + 32'(x);
        return a[AW-1:0];
    endfunction

    function automatic logic in_range(input logic [9:0] x, input logic [8:0] y);
        return (x <= X_MAX) && (y <= Y_MAX);
    endfunction

    logic [AW-1:0] rd_a, wr_a, disp_a, seed_a;
    logic          rd_ok, wr_ok, disp_ok, seed_ok;
    logic          eng_we, seed_we, vb_rise, last_wr, swap;

    assign rd_a    = lin_addr(rd_addr_x, rd_addr_y);
    assign wr_a    = lin_addr(wr_addr_x, wr_addr_y);
    assign disp_a  = lin_addr(disp_addr_x, disp_addr_y);
    assign seed_a  = lin_addr(seed_addr_x, seed_addr_y);
    assign rd_ok   = in_range(rd_addr_x, rd_addr_y);
    assign wr_ok   = in_range(wr_addr_x, wr_addr_y);
    assign disp_ok = in_range(disp_addr_x, disp_addr_y);
    assign seed_ok = in_range(seed_addr_x, seed_addr_y);

    // Out-of-range writes are dropped; seeding is only possible while idle
    assign eng_we  = wr_en && wr_ok;
    assign seed_we = seed_wr_en && seed_ok && (state_q == IDLE);
    assign vb_rise = vblank && !vblank_q;
    assign last_wr = wr_en && (wr_addr_x == X_MAX) && (wr_addr_y == Y_MAX);
    assign swap    = (state_q == DONE) && vb_rise;

    // The display bank as it will be after this edge, so disp_data follows a swap together with bank_sel
    assign bank_sel_d = bank_sel_q ^ swap;

    // Bank 0: engine target while bank 1 is displayed, seed target while bank 0 is displayed
    always_ff @(posedge clk) begin
        if (eng_we && bank_sel_q)
            bank0_mem[wr_a] <= wr_data;
        else if (seed_we && !bank_sel_q)
            bank0_mem[seed_a] <= seed_data;
    end

    // Bank 1: engine target while bank 0 is displayed, seed target while bank 1 is displayed
    always_ff @(posedge clk) begin
        if (eng_we && !bank_sel_q)
            bank1_mem[wr_a] <= wr_data;
        else if (seed_we && bank_sel_q)
            bank1_mem[seed_a] <= seed_data;
    end

    // Engine neighbour read is combinational because the engine samples right after presenting an address
    assign rd_data = rd_ok && (bank_sel_q ? bank1_mem[rd_a] : bank0_mem[rd_a]);

    // Registered scan-out of the display bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            disp_data_q <= 1'b0;
        else
            disp_data_q <= disp_ok && (bank_sel_d ? bank1_mem[disp_a] : bank0_mem[disp_a]);
    end

    // Generation sequencer: launch, wait for the last cell, then swap on the next vblank edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            busy_q      <= 1'b0;
            bank_sel_q  <= 1'b0;
            gen_count_q <= '0;
            vblank_q    <= 1'b0;
        end else begin
            vblank_q <= vblank;
            start_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (run) begin
                        state_q <= START;
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                START: state_q <= RUN;
                RUN: begin
                    // A vblank edge coinciding with the last write is deliberately not used for the swap
                    if (last_wr)
                        state_q <= DONE;
                end
                DONE: begin
                    if (swap) begin
                        bank_sel_q  <= bank_sel_d;
                        gen_count_q <= gen_count_q + GEN_W'(1);
                        if (run) begin
                            state_q <= START;
                            start_q <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign start     = start_q;
    assign busy      = busy_q;
    assign bank_sel  = bank_sel_q;
    assign gen_count = gen_count_q;
    assign disp_data = disp_data_q;

endmodule
